// File: rtl/fpu_types.sv
// rtl/fpu_types.sv - shared FPU types: divider FSM states and counter width
package fpu_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_DATA_WIDTH = 26;
    localparam int DIV_CNT_W      = $clog2(DIV_DATA_WIDTH);

endpackage

// File: rtl/fp_mant_div_step.sv
// rtl/fp_mant_div_step.sv - one combinational restoring division step
module fp_mant_div_step #(
    parameter int DATA_WIDTH = 26
) (
    input  logic [DATA_WIDTH:0]   pr,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  qbit,
    output logic [DATA_WIDTH:0]   pr_next
);

    // One extra bit beyond the partial remainder acts as the borrow/sign.
    logic [DATA_WIDTH+1:0] diff;

    // Trial subtract; keep the difference only when it did not borrow.
    always_comb begin
        diff    = {1'b0, pr} - {2'b00, divisor};
        qbit    = ~diff[DATA_WIDTH+1];
        pr_next = qbit ? diff[DATA_WIDTH:0] : pr;
    end

endmodule

// File: rtl/fp_mant_divider.sv
// rtl/fp_mant_divider.sv - iterative radix-2 restoring mantissa divider (option: FP_MANT_DIVIDER_EARLY_TERM_EN)
module fp_mant_divider
    import fpu_types::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  done,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    div_state_t            state;
    logic [DATA_WIDTH:0]   pr;
    logic [DATA_WIDTH-1:0] div_q;
    logic [CNT_W-1:0]      count;

    logic                  qbit;
    logic [DATA_WIDTH:0]   pr_next;
    logic [DATA_WIDTH-1:0] q_next;

    fp_mant_div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .pr      (pr),
        .divisor (div_q),
        .qbit    (qbit),
        .pr_next (pr_next)
    );

    assign q_next = {quotient[DATA_WIDTH-2:0], qbit};

    // Control FSM: start from any state restarts; RUN retires one quotient bit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pr        <= '0;
            div_q     <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                pr       <= {1'b0, dividend};
                div_q    <= divisor;
                quotient <= '0;
                count    <= '0;
                state    <= RUN;
                busy     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    RUN: begin
                        quotient <= q_next;
`ifdef FP_MANT_DIVIDER_EARLY_TERM_EN
                        // A zero partial remainder means every later bit is zero,
                        // except for a zero divisor, which must keep producing ones.
                        if ((pr_next == '0) && (div_q != '0)) begin
                            quotient  <= q_next << (LAST - count);
                            remainder <= '0;
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else
`endif
                        if (count == LAST) begin
                            remainder <= pr_next[DATA_WIDTH-1:0];
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            pr    <= pr_next << 1;
                            count <= count + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fp_mant_divider.sv
// tb/tb_fp_mant_divider.sv - scoreboard testbench for fp_mant_divider
module tb_fp_mant_divider;

    localparam int W = 26;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         busy;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           chk_r;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   cyc = 0;

    fp_mant_divider #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done quotient=%h remainder=%h required=no done", quotient, remainder);
            end else begin
                cur = sb.pop_front();
                if (quotient !== cur.q) begin
                    bad++;
                    $display("FAIL quotient got=%h exp=%h", quotient, cur.q);
                end
                if (cur.chk_r) begin
                    total++;
                    if (remainder !== cur.r) begin
                        bad++;
                        $display("FAIL remainder got=%h exp=%h", remainder, cur.r);
                    end
                end
            end
        end
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint unsigned num, q;
        num = longint'(a) << (W - 1);
        if (b == '0) begin
            e.q = '1;
            e.r = '0;
            e.chk_r = 1'b0;
        end else begin
            q = num / longint'(b);
            e.q = q[W-1:0];
            e.r = W'(num - q * longint'(b));
            e.chk_r = 1'b1;
        end
        return e;
    endfunction

    function automatic int exp_lat(input exp_t e, input logic [W-1:0] b);
        int tz;
        tz = 0;
`ifdef FP_MANT_DIVIDER_EARLY_TERM_EN
        if (b != '0 && e.r == '0 && e.q != '0) begin
            while (e.q[tz] == 1'b0) tz++;
            return W - 1 - tz + 2;
        end
`else
        if (b == '0) tz = 0;
`endif
        return W + 1 + tz - tz;
    endfunction

    // Launch one operation, push its expectation, and check busy and latency.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit immediate);
        exp_t e;
        int c0, lat, want;
        bit seen;
        if (!immediate) begin
            @(posedge clk);
            #1;
        end
        e = model(a, b);
        want = exp_lat(e, b);
        sb.push_back(e);
        start = 1'b1;
        dividend = a;
        divisor = b;
        c0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        lat = 0;
        for (int i = 0; i < W + 6 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_run got=%b exp=1", busy);
                end
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                lat = cyc - c0;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout a=%h b=%h got=no done exp=done", a, b);
        end else if (lat != want) begin
            bad++;
            $display("FAIL latency a=%h b=%h got=%0d exp=%0d", a, b, lat, want);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        total += 4;
        if (quotient !== '0) begin bad++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
        if (remainder !== '0) begin bad++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_vectors;
        logic [W-1:0] a, b;
        run_op(26'h2000000, 26'h2000000, 1'b0);
        run_op(26'h2000000, 26'h3000000, 1'b0);
        run_op(26'h2000000, 26'h3FFFFFF, 1'b0);
        run_op(26'h3FFFFFF, 26'h2000000, 1'b0);
        run_op(26'h3000000, 26'h2000000, 1'b0);
        run_op(26'h2000000, 26'h0000000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            a = W'($urandom());
            b = W'($urandom());
            a[W-1] = 1'b1;
            b[W-1] = 1'b1;
            run_op(a, b, 1'b0);
        end
    endtask

    task automatic test_abort;
        exp_t e;
        int c0, c1, d0, want;
        bit seen;
        @(posedge clk);
        #1;
        d0 = done_cnt;
        start = 1'b1;
        dividend = 26'h2000000;
        divisor = 26'h3000000;
        c0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cyc < c0 + 10) begin
            @(posedge clk);
            #1;
        end
        e = model(26'h3000000, 26'h2000000);
        want = exp_lat(e, 26'h2000000);
        sb.push_back(e);
        start = 1'b1;
        dividend = 26'h3000000;
        divisor = 26'h2000000;
        c1 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1 && !seen) begin
                seen = 1'b1;
                total++;
                if (cyc - c1 != want) begin
                    bad++;
                    $display("FAIL abort_latency got=%0d exp=%0d", cyc - c1, want);
                end
            end
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL abort_done_count got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        @(posedge clk);
        #1;
        d0 = done_cnt;
        start = 1'b1;
        dividend = 26'h3000000;
        divisor = 26'h2000001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total += 4;
        if (quotient !== '0) begin bad++; $display("FAIL midreset_quotient got=%h exp=0", quotient); end
        if (remainder !== '0) begin bad++; $display("FAIL midreset_remainder got=%h exp=0", remainder); end
        if (done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b exp=0", done); end
        if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        total++;
        if (done_cnt != d0) begin
            bad++;
            $display("FAIL midreset_no_done got=%0d exp=%0d", done_cnt, d0);
        end
        run_op(26'h3000000, 26'h3000000, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_op(26'h2ABCDEF, 26'h3123456, 1'b0);
        run_op(26'h3FFFFFF, 26'h3FFFFFF, 1'b1);
        run_op(26'h2000001, 26'h2FFFFFF, 1'b1);
        run_op(26'h3800000, 26'h2000000, 1'b1);
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
